// File: rtl/fractal_stream_source.sv
// Frame walker that issues interleaved solver reads, aligns the returned
// data to the read latency and streams it through a credit FIFO.
module fractal_stream_source #(
  parameter int NUM_SOLVERS = 29,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int RD_LATENCY = 2,
  parameter int DATA_BITS = 4,
  parameter int OUT_BITS = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int NPIX = WIDTH * HEIGHT,
  localparam int SID_W =
    (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1,
  localparam int WORDS =
    (NPIX + NUM_SOLVERS - 1) / NUM_SOLVERS,
  localparam int ADDR_W =
    (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 one_shot,
  input  logic                 restart,
  input  logic                 invert,
  output logic                 rd_en,
  output logic [SID_W-1:0]     rd_solver_id,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  input  logic                 st_ready,
  output logic                 st_valid,
  output logic                 st_sop,
  output logic                 st_eop,
  output logic [OUT_BITS-1:0]  st_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);

  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int REP = OUT_BITS / DATA_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W = $clog2(RD_LATENCY + 1);
  localparam int CR_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
    logic inv;
  } tag_t;

  typedef struct packed {
    logic                sop;
    logic                eop;
    logic [OUT_BITS-1:0] data;
  } beat_t;

  state_t           state;
  logic [PIX_W-1:0] pix;
  tag_t             pipe [RD_LATENCY];
  logic [IF_W-1:0]  inflight;
  beat_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [CR_W-1:0]  used;
  logic             push;
  logic             pop;
  logic             last_pix;
  logic             eop_acc;
  tag_t             tail;
  beat_t            head;
  beat_t            wbeat;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign tail = pipe[RD_LATENCY-1];
  assign push = tail.vld;
  assign head = mem[rd_ptr];
  assign st_valid = (occ != '0);
  assign pop = st_valid & st_ready;
  assign st_sop = st_valid & head.sop;
  assign st_eop = st_valid & head.eop;
  assign st_data = st_valid ? head.data : '0;
  assign eop_acc = pop & head.eop;
  assign busy = (state != IDLE);
  assign last_pix = (pix == PIX_W'(NPIX - 1));

  // Reads in flight plus buffered beats must never exceed the FIFO.
  assign used = CR_W'(inflight) + CR_W'(occ) - CR_W'(pop);
  assign rd_en = (state == STREAM) && !restart
               && (used < CR_W'(FIFO_DEPTH));

  assign wbeat.sop = tail.sop;
  assign wbeat.eop = tail.eop;
  assign wbeat.data = {REP{rd_data}} ^ {OUT_BITS{tail.inv}};

  // Tag pipeline tracks each read until its data returns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      inflight <= '0;
    end else if (restart) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      inflight <= '0;
    end else begin
      pipe[0] <= {rd_en, rd_en & (pix == '0),
                  rd_en & last_pix, invert};
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      inflight <= inflight + IF_W'(rd_en) - IF_W'(push);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are only visible through occupancy.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wbeat;
  end

  // Solver/address/pixel counters advance per issued read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_solver_id <= '0;
      rd_addr <= '0;
      pix <= '0;
    end else if (restart) begin
      rd_solver_id <= '0;
      rd_addr <= '0;
      pix <= '0;
    end else if (rd_en) begin
      if (last_pix) begin
        rd_solver_id <= '0;
        rd_addr <= '0;
        pix <= '0;
      end else begin
        pix <= pix + PIX_W'(1);
        if (rd_solver_id == SID_W'(NUM_SOLVERS - 1)) begin
          rd_solver_id <= '0;
          rd_addr <= rd_addr + ADDR_W'(1);
        end else begin
          rd_solver_id <= rd_solver_id + SID_W'(1);
        end
      end
    end
  end

  // Frame sequencing, completion pulse and frame counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      frame_done <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (restart) begin
        state <= run ? STREAM : IDLE;
      end else begin
        case (state)
          IDLE: if (run) state <= STREAM;
          STREAM: if (rd_en && last_pix) state <= DRAIN;
          DRAIN: begin
            if (eop_acc) begin
              frame_done <= 1'b1;
              frame_count <= frame_count + 16'd1;
              state <= (run && !one_shot) ? STREAM : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fractal_stream_source.md
Name: fractal_stream_source

Overview:
- Parametrised pixel streamer that replaces the fixed pixel iterator and its hand-built two-stage sideband delay.
- Walks a WIDTH×HEIGHT frame and issues reads to the interleaved solver bank. It aligns the returned data to any read latency, buffers it in a credit-managed FIFO and drives an Avalon-ST video sink.
- Honours backpressure without losing pixels.
- Adds one-shot/continuous frame modes, synchronous abort, colour inversion and frame status.

Parameters:
- NUM_SOLVERS, 29, number of interleaved solvers; pixel p is owned by solver p mod NUM_SOLVERS.
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- RD_LATENCY, 2, cycles from rd_en to valid rd_data (>=1).
- DATA_BITS, 4, solver data width.
- OUT_BITS, 8, stream data width; must be an integer multiple of DATA_BITS.
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+2.
- Derived SID_W = clog2(NUM_SOLVERS).
- Derived ADDR_W = clog2(ceil(WIDTH*HEIGHT/NUM_SOLVERS)).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; enables frame start
- one_shot  in  1  1: stop after the current frame; 0: stream frames back to back
- restart  in  1  synchronous abort and rewind, one-cycle pulse
- invert  in  1  invert stream data, sampled per read
- rd_en  out  1  read strobe to solver bank
- rd_solver_id  out  SID_W  solver select
- rd_addr  out  ADDR_W  address within the selected solver
- rd_data  in  DATA_BITS  solver data, valid RD_LATENCY cycles after rd_en
- st_ready  in  1  sink ready
- st_valid  out  1  beat valid
- st_sop  out  1  start of packet, first pixel of frame
- st_eop  out  1  end of packet, last pixel of frame
- st_data  out  OUT_BITS  pixel data
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when a frame's eop beat is accepted
- frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async, reset_n=0): state IDLE; all counters, FIFO pointers and the in-flight pipeline cleared. Outputs rd_en, st_valid, st_sop, st_eop, busy, frame_done = 0; st_data, rd_solver_id, rd_addr = 0; frame_count = 0.
- Address generation uses counters only, no divider:
  - sid counts 0..NUM_SOLVERS-1 and advances on each issued read.
  - When sid wraps, addr increments.
  - pix counts 0..WIDTH*HEIGHT-1.
  - Pixel 0 is tagged sop; pixel WIDTH*HEIGHT-1 is tagged eop.
- Issue rule:
  - A read is issued (rd_en=1) in STREAM when inflight + occupancy - pop < FIFO_DEPTH.
  - pop = st_valid & st_ready in the same cycle.
  - The rd_solver_id and rd_addr presented with rd_en belong to that read.
- Alignment: a RD_LATENCY-deep shift register carries {valid, sop, eop, invert} alongside each read. rd_data is captured and pushed into the FIFO when the tail entry is valid.
  - Stored data = OUT_BITS/DATA_BITS copies of rd_data, bitwise-inverted if the tagged invert=1.
- Output:
  - st_valid = FIFO not empty.
  - st_data, st_sop and st_eop come from the FIFO head and are held stable while st_valid=1 and st_ready=0.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty.
  - With st_ready held at 1 and the depth rule met, throughput is 1 beat/cycle.
- FSM:
  - IDLE: run=1 -> STREAM with counters at 0.
  - STREAM: last pixel issued -> DRAIN.
  - DRAIN: eop beat accepted -> frame_done=1 and frame_count+1. Then, if run=1 and one_shot=0, go to STREAM in the same cycle, with pixel 0 issuable on the next cycle. Otherwise go to IDLE.
  - Deasserting run mid-frame does not stop the frame; it only prevents the next one.
- restart=1 (any state):
  - Next cycle: FIFO emptied, in-flight tags discarded (late rd_data ignored), counters zeroed, st_valid=0.
  - State becomes STREAM if run=1, else IDLE.
  - frame_count is unchanged and no frame_done is issued.
  - restart has priority over a simultaneous eop acceptance.
- frame_count wraps to 0 after 65535.

Test Plan:
- Bench configuration: WIDTH=8, HEIGHT=4, NUM_SOLVERS=3, RD_LATENCY=2, FIFO_DEPTH=4, solver model returns (sid*5+addr) mod 16.
- st_ready=1, one_shot=1, run=1 -> 32 beats on consecutive cycles.
  - st_sop only on beat 0; st_eop only on beat 31.
  - Beat 31 is read from sid 1, addr 10, giving data 0xFF.
  - Single frame_done pulse; frame_count=1; busy=0 afterwards.
- invert=1 for the whole frame -> beat 0 (sid 0, addr 0) gives st_data=0xFF; beat 1 (sid 1, addr 0) gives 0xAA.
- st_ready held 0 for 20 cycles mid-frame -> rd_en ceases after the FIFO_DEPTH credit is exhausted.
  - st_valid stays 1 with st_data stable.
  - On release, the sequence resumes with no gap, duplicate or loss.
- Random st_ready (50%) over 3 continuous frames (one_shot=0) -> scoreboard matches 96 beats in order.
  - eop of frame n is followed by sop of frame n+1.
  - frame_count=3.
- restart pulsed after beat 13 accepted -> st_valid=0 the next cycle; next accepted beat has sop=1 from sid 0, addr 0; frame_count unchanged.
- reset_n driven low mid-frame asynchronously -> all outputs 0 immediately. After release with run=1, the frame restarts at pixel 0.
